// File: rtl/mux_arbitro_rr.sv
// Round-robin arbiter for two requesters; owns the 2:1 mux select and registers the selected data (optional feature macro: ARB_MAXHOLD_EN).
// Latency: request -> grant 1 cycle, request -> salida_valid 2 cycles; grants are Moore-decoded from the state register.
// Backpressure: none from downstream; a requester holds its level request (and stable data) until granted and done.
module mux_arbitro_rr #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] dato0,
    input  logic [WIDTH-1:0] dato1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             seleccion,
    output logic [WIDTH-1:0] salida,
    output logic             salida_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   last;       // last owner; 1 after reset so requester 0 wins the first tie
    logic   preempt;    // current owner must yield to a waiting competitor
    logic   keep_data;  // granted owner is still requesting this cycle

    // Hold counter is 8 bits wide, so MAX_HOLD must fit in 1..255.
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("mux_arbitro_rr: MAX_HOLD must be in 1..255");
    end

`ifdef ARB_MAXHOLD_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] cnt;

    // The owner yields once it has held MAX_HOLD cycles and the other side is asking.
    assign preempt = (((state == OWN0) && req1) || ((state == OWN1) && req0)) && (cnt == HOLD_LAST);

    // Hold counter: cleared on every state change, saturates while the same owner stays.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state_nxt != state) begin
            cnt <= '0;
        end else if ((state != IDLE) && (cnt != HOLD_LAST)) begin
            cnt <= cnt + 8'd1;
        end
    end
`else
    assign preempt = 1'b0;
`endif

    // Next-state: ties from IDLE go to the requester that did not own last; handover skips IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    state_nxt = last ? OWN0 : OWN1;
                end else if (req0) begin
                    state_nxt = OWN0;
                end else if (req1) begin
                    state_nxt = OWN1;
                end
            end
            OWN0: begin
                if (!req0) begin
                    state_nxt = req1 ? OWN1 : IDLE;
                end else if (preempt) begin
                    state_nxt = OWN1;
                end
            end
            OWN1: begin
                if (!req1) begin
                    state_nxt = req0 ? OWN0 : IDLE;
                end else if (preempt) begin
                    state_nxt = OWN0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register and last-owner tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            if (state_nxt == OWN0) begin
                last <= 1'b0;
            end else if (state_nxt == OWN1) begin
                last <= 1'b1;
            end
        end
    end

    assign gnt0      = (state == OWN0);
    assign gnt1      = (state == OWN1);
    assign seleccion = (state == OWN1);
    assign keep_data = ((state == OWN0) && req0) || ((state == OWN1) && req1);

    // Output register: capture the muxed data only while the granted owner still requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            salida       <= '0;
            salida_valid <= 1'b0;
        end else begin
            salida_valid <= keep_data;
            if (keep_data) begin
                salida <= seleccion ? dato1 : dato0;
            end
        end
    end

endmodule

// File: tb/tb_mux_arbitro_rr.sv
module tb_mux_arbitro_rr;

    logic       clk;
    logic       rst_n;
    logic       req0;
    logic       req1;
    logic [7:0] dato0;
    logic [7:0] dato1;

    logic       gnt0, gnt1, seleccion, salida_valid;
    logic [7:0] salida;
    logic       gnt0_b, gnt1_b, seleccion_b, salida_valid_b;
    logic [7:0] salida_b;

    // Packed observation: {gnt0, gnt1, seleccion, salida_valid, salida}
    logic [11:0] obs;
    logic [11:0] obs_b;
    assign obs   = {gnt0, gnt1, seleccion, salida_valid, salida};
    assign obs_b = {gnt0_b, gnt1_b, seleccion_b, salida_valid_b, salida_b};

    int checks = 0;
    int errors = 0;

    mux_arbitro_rr #(.WIDTH(8), .MAX_HOLD(4)) dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .dato0(dato0), .dato1(dato1),
        .gnt0(gnt0), .gnt1(gnt1), .seleccion(seleccion),
        .salida(salida), .salida_valid(salida_valid)
    );

    mux_arbitro_rr #(.WIDTH(8), .MAX_HOLD(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .dato0(dato0), .dato1(dato1),
        .gnt0(gnt0_b), .gnt1(gnt1_b), .seleccion(seleccion_b),
        .salida(salida_b), .salida_valid(salida_valid_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req0  = 1'b0;
        req1  = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic       r0 [2] = '{1'b1, 1'b1};
        logic [11:0] ev [2] = '{12'h800, 12'h911};
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; dato0 = 8'h11; dato1 = 8'h22;
        #2;
        checks++;
        if (obs !== 12'h000) begin
            errors++;
            $display("FAIL reset_state got %h want %h", obs, 12'h000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req0 = r0[i];
            step();
            checks++;
            if (obs !== ev[i]) begin
                errors++;
                $display("FAIL reset_first_grant[%0d] got %h want %h", i, obs, ev[i]);
            end
        end
    endtask

    task automatic test_idle_drop();
        logic [11:0] ev [2] = '{12'h011, 12'h011};
        req0 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (obs !== ev[i]) begin
                errors++;
                $display("FAIL idle_drop[%0d] got %h want %h", i, obs, ev[i]);
            end
        end
    endtask

    task automatic test_tie();
        logic        r0 [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic        r1 [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [11:0] ev [6] = '{12'h800, 12'h911, 12'h011, 12'h611, 12'h722, 12'h022};
        do_reset();
        dato0 = 8'h11; dato1 = 8'h22;
        for (int i = 0; i < 6; i++) begin
            req0 = r0[i];
            req1 = r1[i];
            step();
            checks++;
            if (obs !== ev[i]) begin
                errors++;
                $display("FAIL tie[%0d] got %h want %h", i, obs, ev[i]);
            end
        end
    endtask

    task automatic test_handover();
        logic        r0 [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic        r1 [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [11:0] ev [6] = '{12'h800, 12'h9A5, 12'h6A5, 12'h73C, 12'h73C, 12'h03C};
        do_reset();
        dato0 = 8'hA5; dato1 = 8'h3C;
        for (int i = 0; i < 6; i++) begin
            req0 = r0[i];
            req1 = r1[i];
            step();
            checks++;
            if (obs !== ev[i]) begin
                errors++;
                $display("FAIL handover[%0d] got %h want %h", i, obs, ev[i]);
            end
        end
    endtask

    task automatic test_contention();
        int          own;
        int          prev_own;
        logic [11:0] exp_v;
        do_reset();
        dato0 = 8'h11; dato1 = 8'h22;
        req0 = 1'b1; req1 = 1'b1;
        prev_own = 0;
        for (int i = 1; i <= 24; i++) begin
`ifdef ARB_MAXHOLD_EN
            own = ((i - 1) / 4) % 2;
`else
            own = 0;
`endif
            exp_v = {own == 0, own == 1, own == 1, i >= 2,
                     (i >= 2) ? ((prev_own == 1) ? 8'h22 : 8'h11) : 8'h00};
            step();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL contention[%0d] got %h want %h", i, obs, exp_v);
            end
            prev_own = own;
        end
        req0 = 1'b0; req1 = 1'b0;
        step();
    endtask

    task automatic test_maxhold1();
        int          own;
        int          prev_own;
        logic [11:0] exp_v;
        do_reset();
        dato0 = 8'h5C; dato1 = 8'hC5;
        req0 = 1'b1; req1 = 1'b1;
        prev_own = 0;
        for (int i = 1; i <= 10; i++) begin
`ifdef ARB_MAXHOLD_EN
            own = (i - 1) % 2;
`else
            own = 0;
`endif
            exp_v = {own == 0, own == 1, own == 1, i >= 2,
                     (i >= 2) ? ((prev_own == 1) ? 8'hC5 : 8'h5C) : 8'h00};
            step();
            checks++;
            if (obs_b !== exp_v) begin
                errors++;
                $display("FAIL maxhold1[%0d] got %h want %h", i, obs_b, exp_v);
            end
            prev_own = own;
        end
        req0 = 1'b0; req1 = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        logic [11:0] ev [2] = '{12'h600, 12'h75A};
        logic [11:0] ev2 [2] = '{12'h800, 12'h977};
        do_reset();
        dato1 = 8'h5A;
        req1 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (obs !== ev[i]) begin
                errors++;
                $display("FAIL reset_mid_pre[%0d] got %h want %h", i, obs, ev[i]);
            end
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 12'h000) begin
            errors++;
            $display("FAIL reset_mid_async got %h want %h", obs, 12'h000);
        end
        checks++;
        if (obs_b !== 12'h000) begin
            errors++;
            $display("FAIL reset_mid_async_b got %h want %h", obs_b, 12'h000);
        end
        req1 = 1'b0;
        #1;
        rst_n = 1'b1;
        dato0 = 8'h77;
        req0 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (obs !== ev2[i]) begin
                errors++;
                $display("FAIL reset_mid_post[%0d] got %h want %h", i, obs, ev2[i]);
            end
        end
        req0 = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_idle_drop();
        test_tie();
        test_handover();
        test_contention();
        test_maxhold1();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
